// File: rtl/vedic_pkg.sv
// Shared definitions for the iterative Vedic multiplier: digit width,
// FSM state encoding and a two's-complement magnitude helper.
package vedic_pkg;

    localparam int unsigned DIGIT_W   = 4;
    // Widest operand the magnitude helper supports.
    localparam int unsigned MAG_MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Magnitude of a zero-extended operand; the caller keeps the low W bits,
    // so the most negative value maps to 2^(W-1).
    function automatic logic [MAG_MAX_W-1:0] twos_mag(
        input logic [MAG_MAX_W-1:0] v,
        input logic                 negative
    );
        return negative ? (~v + MAG_MAX_W'(1)) : v;
    endfunction

endpackage

// File: rtl/vedic_mul_4_4.sv
// Combinational 4x4 unsigned Vedic multiplier built from four 2x2 crosswise
// blocks.
// Ports: a, b - 4-bit operands; product_c - 8-bit combinational product.
module vedic_mul_4_4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] product_c
);

    // 2x2 vertical-and-crosswise multiply.
    function automatic logic [3:0] mul2(input logic [1:0] x, input logic [1:0] y);
        logic       c0;
        logic       c1;
        logic [3:0] r;
        r[0]      = x[0] & y[0];
        {c0, r[1]} = 2'(x[1] & y[0]) + 2'(x[0] & y[1]);
        {c1, r[2]} = 2'(x[1] & y[1]) + 2'(c0);
        r[3]      = c1;
        return r;
    endfunction

    logic [3:0] q_ll;
    logic [3:0] q_hl;
    logic [3:0] q_lh;
    logic [3:0] q_hh;

    assign q_ll = mul2(a[1:0], b[1:0]);
    assign q_hl = mul2(a[3:2], b[1:0]);
    assign q_lh = mul2(a[1:0], b[3:2]);
    assign q_hh = mul2(a[3:2], b[3:2]);

    assign product_c = 8'(q_ll) + (8'(q_hl) << 2) + (8'(q_lh) << 2) + (8'(q_hh) << 4);

endmodule

// File: rtl/vedic_mul_iter.sv
// Multi-cycle W x W multiplier: one 4x4 partial product accumulated per clock,
// unsigned or two's-complement per transaction, valid/ready on both sides.
// Ports:
//   clk, rst_n            - clock, async active-low reset
//   in_valid / in_ready   - operand handshake (in_ready high only in IDLE)
//   a, b, signed_mode     - operands and mode, captured on accept
//   out_valid / out_ready - result handshake
//   product               - 2W-bit result, held until the next completion
//   busy                  - high while calculating or holding a result
module vedic_mul_iter
    import vedic_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   product,
    output logic             busy
);

    localparam int unsigned N  = W / DIGIT_W;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned PW = 2 * W;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if (((W % DIGIT_W) != 0) || (W < DIGIT_W) || (W > MAG_MAX_W)) begin : g_bad_w
        $error("vedic_mul_iter: W must be a multiple of 4 within [4, 64]");
    end

    state_t          state_q, state_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   i_q, i_d;
    logic [CW-1:0]   j_q, j_d;
    logic [W-1:0]    mag_a_q, mag_a_d;
    logic [W-1:0]    mag_b_q, mag_b_d;
    logic            neg_q, neg_d;
    logic [PW-1:0]   product_d;
    logic            out_valid_d;
    logic            in_ready_d;
    logic            busy_d;

    logic [DIGIT_W-1:0] digit_a;
    logic [DIGIT_W-1:0] digit_b;
    logic [7:0]         pp;
    logic [PW-1:0]      pp_shift;
    logic [PW-1:0]      sum;

    // Digit selection and alignment of the current partial product.
    assign digit_a  = DIGIT_W'(mag_a_q >> (DIGIT_W * 32'(i_q)));
    assign digit_b  = DIGIT_W'(mag_b_q >> (DIGIT_W * 32'(j_q)));
    assign pp_shift = PW'(pp) << (DIGIT_W * (32'(i_q) + 32'(j_q)));
    assign sum      = acc_q + pp_shift;

    vedic_mul_4_4 u_core (
        .a         (digit_a),
        .b         (digit_b),
        .product_c (pp)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            i_q       <= '0;
            j_q       <= '0;
            mag_a_q   <= '0;
            mag_b_q   <= '0;
            neg_q     <= 1'b0;
            product   <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            i_q       <= i_d;
            j_q       <= j_d;
            mag_a_q   <= mag_a_d;
            mag_b_q   <= mag_b_d;
            neg_q     <= neg_d;
            product   <= product_d;
            out_valid <= out_valid_d;
            in_ready  <= in_ready_d;
            busy      <= busy_d;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        i_d         = i_q;
        j_d         = j_q;
        mag_a_d     = mag_a_q;
        mag_b_d     = mag_b_q;
        neg_d       = neg_q;
        product_d   = product;
        out_valid_d = out_valid;
        in_ready_d  = in_ready;
        busy_d      = busy;

        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    mag_a_d    = W'(twos_mag(MAG_MAX_W'(a), signed_mode & a[W-1]));
                    mag_b_d    = W'(twos_mag(MAG_MAX_W'(b), signed_mode & b[W-1]));
                    neg_d      = signed_mode & (a[W-1] ^ b[W-1]);
                    acc_d      = '0;
                    i_d        = '0;
                    j_d        = '0;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = CALC;
                end
            end
            CALC: begin
                if ((i_q == LAST) && (j_q == LAST)) begin
                    // Final step folds the last partial product straight into the result.
                    product_d   = neg_q ? (-sum) : sum;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    acc_d = sum;
                    if (i_q == LAST) begin
                        i_d = '0;
                        j_d = j_q + CW'(1);
                    end else begin
                        i_d = i_q + CW'(1);
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_vedic_mul_iter.sv
// Self-checking bench for vedic_mul_iter at W=4, 8 and 16 with a result
// scoreboard; directed cases followed by randomised handshake regression.
module tb_vedic_mul_iter;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic        sm;
    logic [15:0] a_t;
    logic [15:0] b_t;
    int          sel;

    logic        iv4, iv8, iv16;
    logic        ir4, ir8, ir16;
    logic        ov4, ov8, ov16;
    logic        bz4, bz8, bz16;
    logic [7:0]  p4;
    logic [15:0] p8;
    logic [31:0] p16;

    logic        o_in_ready;
    logic        o_out_valid;
    logic        o_busy;
    logic [31:0] o_product;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] sb[$];

    assign iv4  = in_valid && (sel == 0);
    assign iv8  = in_valid && (sel == 1);
    assign iv16 = in_valid && (sel == 2);

    vedic_mul_iter #(.W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
        .a(a_t[3:0]), .b(b_t[3:0]), .signed_mode(sm), .out_valid(ov4),
        .out_ready(out_ready), .product(p4), .busy(bz4)
    );
    vedic_mul_iter #(.W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
        .a(a_t[7:0]), .b(b_t[7:0]), .signed_mode(sm), .out_valid(ov8),
        .out_ready(out_ready), .product(p8), .busy(bz8)
    );
    vedic_mul_iter #(.W(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
        .a(a_t), .b(b_t), .signed_mode(sm), .out_valid(ov16),
        .out_ready(out_ready), .product(p16), .busy(bz16)
    );

    always_comb begin
        case (sel)
            0: begin
                o_in_ready = ir4; o_out_valid = ov4; o_busy = bz4; o_product = 32'(p4);
            end
            2: begin
                o_in_ready = ir16; o_out_valid = ov16; o_busy = bz16; o_product = p16;
            end
            default: begin
                o_in_ready = ir8; o_out_valid = ov8; o_busy = bz8; o_product = 32'(p8);
            end
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int width_of(input int s_sel);
        return (s_sel == 0) ? 4 : ((s_sel == 2) ? 16 : 8);
    endfunction

    // Reference product, reduced to 2w bits.
    function automatic logic [31:0] ref_mul(input logic [15:0] av, input logic [15:0] bv,
                                            input bit s, input int w);
        longint la;
        longint lb;
        longint pr;
        la = longint'(av);
        lb = longint'(bv);
        if (s && av[w-1]) la = la - (longint'(1) << w);
        if (s && bv[w-1]) lb = lb - (longint'(1) << w);
        pr = la * lb;
        return 32'(pr & ((longint'(1) << (2 * w)) - 1));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One directed transaction; hold>0 stalls the result and offers a stray operand.
    task automatic run_txn(input int s_sel, input bit s, input logic [15:0] av,
                           input logic [15:0] bv, input int lat, input int hold);
        int          n;
        logic [31:0] exp_p;
        sel       = s_sel;
        out_ready = (hold == 0);
        check("in_ready_idle", 32'(o_in_ready), 32'd1);
        a_t = av; b_t = bv; sm = s; in_valid = 1'b1;
        sb.push_back(ref_mul(av, bv, s, width_of(s_sel)));
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!o_out_valid && n < 400) begin
            check("busy_calc", 32'(o_busy), 32'd1);
            check("in_ready_calc", 32'(o_in_ready), 32'd0);
            tick();
            n++;
        end
        check("latency", 32'(n), 32'(lat));
        exp_p = sb.pop_front();
        check("product", o_product, exp_p);
        check("busy_done", 32'(o_busy), 32'd1);
        for (int k = 0; k < hold; k++) begin
            a_t = 16'd2; b_t = 16'd2; sm = 1'b0; in_valid = 1'b1;
            check("hold_out_valid", 32'(o_out_valid), 32'd1);
            check("hold_product", o_product, exp_p);
            check("hold_in_ready", 32'(o_in_ready), 32'd0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("out_valid_drop", 32'(o_out_valid), 32'd0);
        check("in_ready_back", 32'(o_in_ready), 32'd1);
        check("busy_drop", 32'(o_busy), 32'd0);
        check("product_kept", o_product, exp_p);
    endtask

    // Random operands, mode, in_valid gaps and out_ready stalls.
    task automatic run_random(input int s_sel, input int ntx);
        int          sent;
        int          got;
        int          budget;
        int          w;
        bit          fired;
        logic [15:0] mask;
        sel = s_sel;
        w = width_of(s_sel);
        mask = 16'((32'd1 << w) - 1);
        sent = 0; got = 0; in_valid = 1'b0;
        budget = ntx * ((w * w) / 16 + 20);
        while (got < ntx && budget > 0) begin
            if (!in_valid && sent < ntx && $urandom_range(0, 1) == 1) begin
                a_t = 16'($urandom) & mask;
                b_t = 16'($urandom) & mask;
                sm = 1'($urandom_range(0, 1));
                in_valid = 1'b1;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            if (o_out_valid && out_ready) begin
                check("rand_sb_depth", 32'(sb.size()), 32'd1);
                if (sb.size() > 0) check("rand_product", o_product, sb.pop_front());
                got++;
            end
            fired = in_valid && o_in_ready;
            if (fired) begin
                sb.push_back(ref_mul(a_t, b_t, sm, w));
                sent++;
            end
            tick();
            budget--;
            if (fired) in_valid = 1'b0;
        end
        check("rand_got", 32'(got), 32'(ntx));
        check("rand_sent", 32'(sent), 32'(ntx));
        check("rand_sb_empty", 32'(sb.size()), 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        sb.delete();
    endtask

    initial begin
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sm = 1'b0;
        a_t = '0; b_t = '0; sel = 1;
        #1 rst_n = 1'b0;
        tick();
        tick();
        check("rst_in_ready", 32'(o_in_ready), 32'd1);
        check("rst_out_valid", 32'(o_out_valid), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_product", o_product, 32'd0);
        rst_n = 1'b1;
        tick();

        run_txn(1, 1'b0, 16'd13, 16'd11, 4, 0);
        run_txn(1, 1'b0, 16'hFF, 16'hFF, 4, 0);
        run_txn(1, 1'b1, 16'h80, 16'h80, 4, 0);
        run_txn(1, 1'b1, 16'hFF, 16'h7F, 4, 0);
        run_txn(1, 1'b1, 16'h80, 16'h01, 4, 0);

        run_txn(1, 1'b0, 16'd7, 16'd9, 4, 5);
        run_txn(1, 1'b0, 16'd2, 16'd2, 4, 0);

        // Reset during the second CALC cycle of 200*100.
        sel = 1; a_t = 16'd200; b_t = 16'd100; sm = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(o_out_valid), 32'd0);
        check("midrst_product", o_product, 32'd0);
        check("midrst_in_ready", 32'(o_in_ready), 32'd1);
        check("midrst_busy", 32'(o_busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_txn(1, 1'b0, 16'd3, 16'd5, 4, 0);

        run_txn(0, 1'b0, 16'd15, 16'd15, 1, 0);
        run_txn(0, 1'b1, 16'h8, 16'h7, 1, 0);
        run_txn(2, 1'b0, 16'hFFFF, 16'hFFFF, 16, 0);
        run_txn(2, 1'b1, 16'h8000, 16'h7FFF, 16, 0);

        run_random(1, 1000);
        run_random(2, 1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
